// File: rtl/event_stat_regs.sv
// Wishbone statistics block: NUM_CH event counters with wrap/saturate, sticky overflow,
// and an atomic snapshot into shadow registers (manual or periodic).
module event_stat_regs #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WB_ADR_W   = 13,
    parameter logic [31:0] PERIOD_RST = 32'd0
) (
    input  logic                wb_clk_i,
    input  logic                rst_n_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [WB_ADR_W-1:0] wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_rty_o,
    input  logic [NUM_CH-1:0]   event_inc_i,
    output logic                snap_o,
    output logic [NUM_CH-1:0]   overflow_o
);

    localparam logic [4:0] ADR_CTRL   = 5'd0;
    localparam logic [4:0] ADR_ENABLE = 5'd1;
    localparam logic [4:0] ADR_PERIOD = 5'd2;
    localparam logic [4:0] ADR_OVF    = 5'd3;
    localparam logic [4:0] ADR_SEQ    = 5'd4;
    localparam int unsigned ADR_SHADOW = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              ack_q;
    logic              acc;
    logic              wr_en;
    logic [4:0]        word;
    logic [31:0]       wmask;
    logic [31:0]       rd_data;

    logic              force_q;
    logic              clr_q;
    logic              sat_q;
    logic [NUM_CH-1:0] enable_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [31:0]       period_q;
    logic [31:0]       timer_q;
    logic [31:0]       seq_q;

    logic [CNT_W-1:0]  live_q   [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  live_nxt [NUM_CH];

    logic              manual_snap;
    logic              auto_snap;
    logic              snap_req;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] w1c;
    logic              unused_adr;

    assign acc      = wb_cyc_i && wb_stb_i;
    assign wb_ack_o = ack_q && acc && rst_n_i;
    assign wr_en    = wb_ack_o && wb_we_i;
    assign word     = wb_adr_i[2 +: 5];
    assign wmask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    assign unused_adr = ^{wb_adr_i[1:0], wb_adr_i[WB_ADR_W-1:7]};

    assign overflow_o = ovf_q;

    assign manual_snap = wr_en && (word == ADR_CTRL) && wb_sel_i[0] && wb_dat_i[1];
    assign auto_snap   = (period_q != '0) && !force_q && (timer_q == period_q - 32'd1);
    assign snap_req    = manual_snap || auto_snap;

    assign inc = event_inc_i & enable_q;
    assign w1c = (wr_en && (word == ADR_OVF)) ? NUM_CH'(wb_dat_i & wmask) : '0;

    // Clear-on-snap restarts from 0 but still absorbs this cycle's increment.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            live_nxt[i] = live_q[i];
            ovf_set[i]  = 1'b0;
            if (snap_req && clr_q) begin
                live_nxt[i] = '0;
            end
            if (inc[i]) begin
                if (live_nxt[i] == CNT_MAX) begin
                    ovf_set[i]  = 1'b1;
                    live_nxt[i] = sat_q ? CNT_MAX : '0;
                end else begin
                    live_nxt[i] = live_nxt[i] + CNT_W'(1);
                end
            end
            if (force_q) begin
                live_nxt[i] = '0;
                ovf_set[i]  = 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (word)
            ADR_CTRL:   rd_data = {28'd0, sat_q, clr_q, 1'b0, force_q};
            ADR_ENABLE: rd_data = 32'(enable_q);
            ADR_PERIOD: rd_data = period_q;
            ADR_OVF:    rd_data = 32'(ovf_q);
            ADR_SEQ:    rd_data = seq_q;
            default: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (word == 5'(ADR_SHADOW + i)) begin
                        rd_data = 32'(shadow_q[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i) begin
            ack_q    <= 1'b0;
            wb_dat_o <= '0;
            snap_o   <= 1'b0;
            force_q  <= 1'b0;
            clr_q    <= 1'b0;
            sat_q    <= 1'b0;
            enable_q <= '1;
            ovf_q    <= '0;
            period_q <= PERIOD_RST;
            timer_q  <= '0;
            seq_q    <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            ack_q  <= acc;
            snap_o <= snap_req;

            // Read data is captured in the first cycle so a later snapshot cannot tear it.
            if (acc && !ack_q) begin
                wb_dat_o <= rd_data;
            end

            if (snap_req) begin
                seq_q <= seq_q + 32'd1;
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                live_q[i] <= live_nxt[i];
                if (snap_req) begin
                    shadow_q[i] <= live_q[i];
                end
            end

            ovf_q <= (ovf_q & ~w1c) | ovf_set;

            if (force_q || (period_q == '0)) begin
                timer_q <= '0;
            end else if (wr_en && (word == ADR_PERIOD)) begin
                timer_q <= '0;
            end else if (auto_snap) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 32'd1;
            end

            if (wr_en) begin
                case (word)
                    ADR_CTRL: begin
                        if (wb_sel_i[0]) begin
                            force_q <= wb_dat_i[0];
                            clr_q   <= wb_dat_i[2];
                            sat_q   <= wb_dat_i[3];
                        end
                    end
                    ADR_ENABLE: enable_q <= (enable_q & ~NUM_CH'(wmask)) | NUM_CH'(wb_dat_i & wmask);
                    ADR_PERIOD: period_q <= (period_q & ~wmask) | (wb_dat_i & wmask);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_event_stat_regs.sv
// Self-checking bench for event_stat_regs: constant tables, directed corner sequences,
// and random traffic checked against a cycle-level behavioural model.
module tb_event_stat_regs;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int WB_ADR_W = 13;
    localparam logic [31:0] PERIOD_RST = 32'd0;
    localparam int unsigned MAXV = (1 << CNT_W) - 1;

    logic                wb_clk_i = 1'b0;
    logic                rst_n_i;
    logic                wb_cyc_i, wb_stb_i, wb_we_i;
    logic [WB_ADR_W-1:0] wb_adr_i;
    logic [31:0]         wb_dat_i;
    logic [3:0]          wb_sel_i;
    logic [31:0]         wb_dat_o;
    logic                wb_ack_o, wb_err_o, wb_rty_o;
    logic [NUM_CH-1:0]   event_inc_i;
    logic                snap_o;
    logic [NUM_CH-1:0]   overflow_o;

    event_stat_regs #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .WB_ADR_W  (WB_ADR_W),
        .PERIOD_RST(PERIOD_RST)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .rst_n_i    (rst_n_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_rty_o   (wb_rty_o),
        .event_inc_i(event_inc_i),
        .snap_o     (snap_o),
        .overflow_o (overflow_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;
    int snap_cnt = 0;
    int since_snap = 0;

    // Behavioural model state
    int unsigned m_live[NUM_CH];
    int unsigned m_sh[NUM_CH];
    bit          m_ovf[NUM_CH];
    bit          m_en[NUM_CH];
    bit          m_force, m_clr, m_sat, m_snap_o;
    logic [31:0] m_period, m_timer, m_seq;

    // Write commit presented to the model on the ack edge
    bit          commit = 1'b0;
    logic [4:0]  c_word;
    logic [31:0] c_data;
    logic [3:0]  c_sel;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ovf_vec();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) r[i] = m_ovf[i];
        return r;
    endfunction

    function automatic logic [31:0] model_read(logic [4:0] w);
        logic [31:0] r;
        r = '0;
        case (w)
            5'd0: r = {28'd0, m_sat, m_clr, 1'b0, m_force};
            5'd1: for (int i = 0; i < NUM_CH; i++) r[i] = m_en[i];
            5'd2: r = m_period;
            5'd3: r = ovf_vec();
            5'd4: r = m_seq;
            default: if (w >= 16 && int'(w) < 16 + NUM_CH) r = 32'(m_sh[w - 16]);
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_live[i] = 0; m_sh[i] = 0; m_ovf[i] = 0; m_en[i] = 1;
        end
        m_force = 0; m_clr = 0; m_sat = 0; m_snap_o = 0;
        m_period = PERIOD_RST; m_timer = 0; m_seq = 0;
    endtask

    task automatic model_step(logic [NUM_CH-1:0] ev);
        bit man, auto_s, snap;
        logic [31:0] m, w1c;
        int unsigned inc, start;
        man    = commit && c_word == 5'd0 && c_sel[0] && c_data[1];
        auto_s = (m_period != 0) && !m_force && (m_timer == m_period - 1);
        snap   = man || auto_s;
        w1c    = (commit && c_word == 5'd3) ? bmerge(32'd0, c_data, c_sel) : 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w1c[i]) m_ovf[i] = 0;
            inc = (ev[i] && m_en[i]) ? 1 : 0;
            if (snap) m_sh[i] = m_live[i];
            if (m_force) begin
                m_live[i] = 0;
            end else begin
                start = (snap && m_clr) ? 0 : m_live[i];
                if (start + inc > MAXV) begin
                    m_ovf[i]  = 1;
                    m_live[i] = m_sat ? MAXV : (start + inc) % (MAXV + 1);
                end else begin
                    m_live[i] = start + inc;
                end
            end
        end
        if (snap) m_seq = m_seq + 1;
        if (m_force || m_period == 0 || (commit && c_word == 5'd2) || auto_s) m_timer = 0;
        else m_timer = m_timer + 1;
        if (commit) begin
            case (c_word)
                5'd0: begin
                    m = bmerge({28'd0, m_sat, m_clr, 1'b0, m_force}, c_data, c_sel);
                    m_force = m[0]; m_clr = m[2]; m_sat = m[3];
                end
                5'd1: begin
                    m = bmerge(model_read(5'd1), c_data, c_sel);
                    for (int i = 0; i < NUM_CH; i++) m_en[i] = m[i];
                end
                5'd2: m_period = bmerge(m_period, c_data, c_sel);
                default: ;
            endcase
        end
        m_snap_o = snap;
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        if (!rst_n_i) model_reset();
        else model_step(event_inc_i);
        @(negedge wb_clk_i);
        check("snap_o", 32'(snap_o), 32'(m_snap_o));
        check("overflow_o", 32'(overflow_o), ovf_vec());
        if (snap_o) begin
            snap_cnt++;
            since_snap = 0;
        end else begin
            since_snap++;
        end
    endtask

    task automatic wb_access(input bit we, input logic [4:0] w, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd,
                             output logic [31:0] exp_rd, output bit ack_ok);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
        wb_adr_i = '0; wb_adr_i[6:2] = w;
        wb_dat_i = d; wb_sel_i = s;
        exp_rd = model_read(w);
        #1;
        ack_ok = (wb_ack_o === 1'b0);
        tick();
        ack_ok = ack_ok && (wb_ack_o === 1'b1);
        rd = wb_dat_o;
        commit = we; c_word = w; c_data = d; c_sel = s;
        tick();
        commit = 0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        tick();
    endtask

    task automatic wr(logic [4:0] w, logic [31:0] d, logic [3:0] s = 4'hF);
        logic [31:0] rd, e;
        bit ok;
        wb_access(1, w, d, s, rd, e, ok);
        check("wr_ack", 32'(ok), 32'd1);
    endtask

    task automatic rd_const(string name, logic [4:0] w, logic [31:0] exp);
        logic [31:0] rd, e;
        bit ok;
        wb_access(0, w, '0, 4'hF, rd, e, ok);
        check({name, "_ack"}, 32'(ok), 32'd1);
        check(name, rd, exp);
    endtask

    task automatic rd_model(logic [4:0] w);
        logic [31:0] rd, e;
        bit ok;
        wb_access(0, w, '0, 4'hF, rd, e, ok);
        check("rd_ack", 32'(ok), 32'd1);
        check($sformatf("rd_w%0d", w), rd, e);
    endtask

    task automatic pulse(logic [NUM_CH-1:0] mask, int n);
        for (int k = 0; k < n; k++) begin
            event_inc_i = mask;
            tick();
        end
        event_inc_i = '0;
    endtask

    task automatic wait_snap(output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (snap_o !== 1'b1 && gap < 300);
        check("snap_seen", 32'(snap_o), 32'd1);
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  word;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    initial begin
        int gap, s1, c0;
        logic [31:0] rd, e, d;
        bit ok;
        logic [4:0] words [11];

        words = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd16, 5'd17, 5'd18, 5'd19, 5'd5, 5'd31};

        vt.push_back('{0, 5'd0,  32'h0,        4'hF, 32'h0,        "ctrl_rst"});
        vt.push_back('{0, 5'd1,  32'h0,        4'hF, 32'hF,        "enable_rst"});
        vt.push_back('{0, 5'd2,  32'h0,        4'hF, PERIOD_RST,   "period_rst"});
        vt.push_back('{0, 5'd3,  32'h0,        4'hF, 32'h0,        "ovf_rst"});
        vt.push_back('{0, 5'd4,  32'h0,        4'hF, 32'h0,        "seq_rst"});
        vt.push_back('{0, 5'd16, 32'h0,        4'hF, 32'h0,        "sh0_rst"});
        vt.push_back('{0, 5'd17, 32'h0,        4'hF, 32'h0,        "sh1_rst"});
        vt.push_back('{0, 5'd18, 32'h0,        4'hF, 32'h0,        "sh2_rst"});
        vt.push_back('{0, 5'd19, 32'h0,        4'hF, 32'h0,        "sh3_rst"});
        vt.push_back('{0, 5'd5,  32'h0,        4'hF, 32'h0,        "unused5"});
        vt.push_back('{0, 5'd20, 32'h0,        4'hF, 32'h0,        "unused20"});
        vt.push_back('{0, 5'd31, 32'h0,        4'hF, 32'h0,        "unused31"});
        vt.push_back('{1, 5'd1,  32'h0,        4'h0, 32'h0,        ""});
        vt.push_back('{0, 5'd1,  32'h0,        4'hF, 32'hF,        "enable_sel0"});
        vt.push_back('{1, 5'd2,  32'h12345678, 4'h5, 32'h0,        ""});
        vt.push_back('{0, 5'd2,  32'h0,        4'hF, 32'h00340078, "period_bytes"});
        vt.push_back('{1, 5'd2,  32'h0,        4'hF, 32'h0,        ""});
        vt.push_back('{0, 5'd2,  32'h0,        4'hF, 32'h0,        "period_zero"});
        vt.push_back('{1, 5'd4,  32'hFFFF,     4'hF, 32'h0,        ""});
        vt.push_back('{0, 5'd4,  32'h0,        4'hF, 32'h0,        "seq_ro"});
        vt.push_back('{1, 5'd16, 32'hAA,       4'hF, 32'h0,        ""});
        vt.push_back('{0, 5'd16, 32'h0,        4'hF, 32'h0,        "shadow_ro"});
        vt.push_back('{1, 5'd0,  32'hC,        4'hF, 32'h0,        ""});
        vt.push_back('{0, 5'd0,  32'h0,        4'hF, 32'hC,        "ctrl_rw"});
        vt.push_back('{1, 5'd0,  32'h0,        4'hF, 32'h0,        ""});
        vt.push_back('{1, 5'd1,  32'hA,        4'h1, 32'h0,        ""});
        vt.push_back('{0, 5'd1,  32'h0,        4'hF, 32'hA,        "enable_rw"});
        vt.push_back('{1, 5'd1,  32'hF,        4'hF, 32'h0,        ""});

        rst_n_i = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; event_inc_i = '0;
        model_reset();
        repeat (3) tick();
        rst_n_i = 1;
        tick();
        check("dat_o_rst", wb_dat_o, 32'd0);
        check("ack_o_rst", 32'(wb_ack_o), 32'd0);

        foreach (vt[k]) begin
            if (vt[k].we) wr(vt[k].word, vt[k].data, vt[k].sel);
            else rd_const(vt[k].name, vt[k].word, vt[k].exp);
        end

        // Basic counting and manual snapshot
        pulse(4'b0001, 7);
        pulse(4'b0101, 3);
        c0 = snap_cnt;
        wr(5'd0, 32'h2);
        check("snap_pulses", snap_cnt - c0, 1);
        rd_const("sh0_10", 5'd16, 32'd10);
        rd_const("sh2_3", 5'd18, 32'd3);
        rd_const("sh1_0", 5'd17, 32'd0);
        rd_const("seq_1", 5'd4, 32'd1);
        rd_const("ctrl_snap_rd0", 5'd0, 32'd0);
        pulse(4'b0001, 2);
        wr(5'd0, 32'h2);
        rd_const("sh0_keep", 5'd16, 32'd12);
        rd_const("seq_2", 5'd4, 32'd2);

        // Wrap mode overflow
        wr(5'd0, 32'h1);
        wr(5'd0, 32'h0);
        pulse(4'b0010, MAXV + 2);
        check("ovf_o_wrap", 32'(overflow_o), 32'h2);
        wr(5'd0, 32'h2);
        rd_const("sh1_wrap", 5'd17, 32'd1);
        rd_const("ovf_wrap", 5'd3, 32'h2);
        wr(5'd3, 32'h2);
        rd_const("ovf_w1c", 5'd3, 32'h0);

        // Saturate mode overflow, then W1C racing a new overflow
        wr(5'd0, 32'h9);
        wr(5'd0, 32'h8);
        pulse(4'b0010, MAXV + 2);
        wr(5'd0, 32'hA);
        rd_const("sh1_sat", 5'd17, MAXV);
        rd_const("ovf_sat", 5'd3, 32'h2);
        event_inc_i = 4'b0010;
        wr(5'd3, 32'h2);
        event_inc_i = '0;
        rd_const("ovf_race", 5'd3, 32'h2);
        wr(5'd3, 32'h2);
        rd_const("ovf_clr2", 5'd3, 32'h0);

        // Periodic snapshot with clear_on_snap
        wr(5'd0, 32'h1);
        wr(5'd0, 32'h4);
        event_inc_i = 4'b1000;
        wr(5'd2, 32'd100);
        wait_snap(gap);
        wait_snap(gap);
        check("period_gap", gap, 100);
        wait_snap(gap);
        check("period_gap2", gap, 100);
        rd_const("sh3_100", 5'd19, 32'd100);
        wb_access(0, 5'd4, '0, 4'hF, rd, e, ok);
        check("seq_rd_ack", 32'(ok), 32'd1);
        check("seq_rd", rd, e);
        s1 = int'(rd);
        while (since_snap < 98) tick();
        c0 = snap_cnt;
        wr(5'd0, 32'h6);
        check("coincident_pulses", snap_cnt - c0, 1);
        rd_const("seq_coincident", 5'd4, 32'(s1 + 1));
        rd_const("sh3_coincident", 5'd19, 32'd100);
        event_inc_i = '0;
        wr(5'd2, 32'd0);

        // Disabled channel
        wr(5'd0, 32'h1);
        wr(5'd0, 32'h0);
        wr(5'd1, 32'hE);
        pulse(4'b0001, 5);
        wr(5'd0, 32'h2);
        rd_const("sh0_disabled", 5'd16, 32'd0);
        wr(5'd1, 32'hF);

        // force_reset holds live counters at zero
        wr(5'd0, 32'h1);
        pulse(4'b1111, 6);
        wr(5'd0, 32'h3);
        rd_const("sh0_force", 5'd16, 32'd0);
        rd_const("sh3_force", 5'd19, 32'd0);
        rd_model(5'd4);
        wr(5'd0, 32'h0);
        pulse(4'b0001, 5);
        wr(5'd0, 32'h2);
        rd_const("sh0_after_force", 5'd16, 32'd5);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            event_inc_i = NUM_CH'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                tick();
            end else begin
                logic [4:0] w;
                bit we;
                w  = words[$urandom_range(0, 10)];
                we = $urandom_range(0, 1) == 1;
                d  = $urandom;
                if (w == 5'd0) d = (d & 32'hE) | (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
                if (w == 5'd2) d = $urandom_range(0, 12);
                wb_access(we, w, d, 4'($urandom), rd, e, ok);
                check("rand_ack", 32'(ok), 32'd1);
                if (!we) check($sformatf("rand_rd_w%0d", w), rd, e);
            end
        end
        event_inc_i = '0;
        for (int w = 0; w < 5; w++) rd_model(5'(w));
        for (int w = 16; w < 16 + NUM_CH; w++) rd_model(5'(w));

        // Reset in the middle of a write access
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
        wb_adr_i = '0; wb_adr_i[6:2] = 5'd1;
        wb_dat_i = 32'h0; wb_sel_i = 4'hF;
        tick();
        check("mid_ack_up", 32'(wb_ack_o), 32'd1);
        commit = 1; c_word = 5'd1; c_data = 32'h0; c_sel = 4'hF;
        rst_n_i = 0;
        #1;
        check("mid_ack_drop", 32'(wb_ack_o), 32'd0);
        tick();
        commit = 0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        rst_n_i = 1;
        tick();
        rd_const("mid_enable", 5'd1, 32'hF);
        rd_const("mid_seq", 5'd4, 32'd0);
        rd_const("mid_period", 5'd2, PERIOD_RST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/event_stat_regs.md
Name: event_stat_regs

Overview:
- Parametrised Wishbone statistics/register block for the event path. It is the successor to the fixed four-plus-two counter bank.
- Provides NUM_CH per-channel event counters of configurable width, with per-channel enable, wrap or saturate mode and sticky overflow flags.
- Reads are coherent: an atomic snapshot copies all live counters into shadow registers, triggered manually or by a periodic timer.
- Single clock domain. Increment pulses must already be synchronised to wb_clk_i by the caller.

Parameters:
- NUM_CH, 4: number of counter channels, 1..16.
- CNT_W, 32: counter width, 1..32; shadow reads are zero-extended to 32 bits.
- WB_ADR_W, 13: Wishbone address width.
- PERIOD_RST, 0: reset value of the PERIOD register; 0 disables auto-snapshot.

Ports:
- wb_clk_i  in  1  sole clock.
- rst_n_i  in  1  synchronous active-low reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  Wishbone write enable.
- wb_adr_i  in  WB_ADR_W  byte address; word select is wb_adr_i[2 +: 5].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lanes.
- wb_dat_o  out  32  registered read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  tied 0.
- wb_rty_o  out  1  tied 0.
- event_inc_i  in  NUM_CH  one-cycle increment pulse per channel.
- snap_o  out  1  one-cycle pulse on every snapshot.
- overflow_o  out  NUM_CH  sticky overflow flags.

Behaviour:
- Reset: rst_n_i low at a clock edge clears all of the following; all outputs read 0 after reset.
  - live counters, shadows, overflow flags
  - CTRL, SEQ, period timer
  - ENABLE is set to all-ones
  - PERIOD is set to PERIOD_RST
  - wb_ack_o, wb_dat_o, snap_o
- Wishbone handshake:
  - Internal ack register <= cyc&&stb every cycle; wb_ack_o = ack&&cyc&&stb. This gives one wait state and exactly one ack per access.
  - Read data is latched on the first cycle of the access.
  - A write takes effect on the ack cycle, honouring wb_sel_i per byte.
- Register map (word index):
  - 0 CTRL, R/W:
    - bit0 force_reset: while 1, live counters and the period timer are held at 0; shadows are kept.
    - bit1 snap: write 1 to request a snapshot; self-clears and reads 0.
    - bit2 clear_on_snap.
    - bit3 saturate: 1 = saturate, 0 = wrap.
  - 1 ENABLE, R/W, bits[NUM_CH-1:0]: a disabled channel ignores event_inc_i.
  - 2 PERIOD, R/W, 32 bits: auto-snapshot interval in cycles; 0 disables. Any write to PERIOD zeroes the timer.
  - 3 OVF, R/W1C, bits[NUM_CH-1:0]: sticky overflow flags.
  - 4 SEQ, RO, 32 bits: snapshot count, wraps at 2^32.
  - 16+i SHADOW[i], RO, for i < NUM_CH.
  - Unused indices read 0; writes to them are ignored.
- Counting:
  - An enabled pulse adds 1 to the channel's live counter on the next edge.
  - At value 2^CNT_W-1 with a pulse: wrap mode goes to 0; saturate mode holds. Either way the channel's OVF flag is set.
  - If a W1C write and a new overflow occur in the same cycle, the overflow wins and the flag stays 1.
- Period timer:
  - Runs when PERIOD != 0 and force_reset == 0.
  - When timer == PERIOD-1: auto-snapshot fires and the timer goes to 0; otherwise timer+1.
- Snapshot (manual request or auto):
  - In one cycle: every SHADOW[i] <= live[i] value before that cycle's increment; SEQ+1; snap_o=1 for that cycle.
  - With clear_on_snap, live[i] <= 0 + that cycle's enabled increment, so no event is lost.
  - A manual and an auto snapshot in the same cycle produce a single snapshot; SEQ increments by 1.
  - A snapshot while force_reset=1 still copies (zeros) and increments SEQ.
- Shadow coherence: a read of SHADOW returns its value at the data-latch cycle. A snapshot during the ack wait state does not alter that returned data.
- Reset mid-access: the ack is dropped and the write is discarded.

Test Plan:
- Reset, then read all registers:
  - PERIOD=PERIOD_RST, ENABLE=all-ones (NUM_CH ones), SEQ=0, SHADOW=0.
  - Every ack arrives exactly 1 cycle after stb.
- 10 pulses on ch0 and 3 on ch2, manual snap:
  - SHADOW0=10, SHADOW2=3, SEQ=1, snap_o high for one cycle.
  - Live counters keep counting unless clear_on_snap is set.
- CNT_W=4, saturate=0, 17 pulses on ch1 then snap: SHADOW1=1, OVF[1]=1. Write 1 to OVF[1]: reads 0.
- Same test with saturate=1: SHADOW1=15, OVF[1]=1.
- PERIOD=100, clear_on_snap=1, constant pulses on ch3:
  - snap_o every 100 cycles, SHADOW3=100 each interval, SEQ increments by 1 per interval.
  - A manual snap coincident with the auto snap gives a single SEQ increment.
- ENABLE=0b1110, pulses on ch0: SHADOW0 stays 0.
- force_reset=1 with pulses: live counters stay 0. Clear force_reset, 5 pulses, snap: SHADOW reads 5.
